// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares the single ram256x8 data memory between the pipeline MEM stage and a
// debug/loader requester. The MEM stage wins every conflict. A debug request
// blocked for MAX_WAIT consecutive cycles forces a one-cycle pipeline stall,
// and the debug access is served during that stall.
//
// Ports
//   clk, R                  clock, synchronous active-high reset
//   mem_E/RW/Size/A/DI      MEM stage access (from EX_MEM)
//   mem_DO                  read data back to the MEM stage (= ram_DO)
//   mem_stall               pipeline hold, high only in the STALL state
//   dbg_req/RW/Size/A/DI    debug access, req held until dbg_ack
//   dbg_ack                 registered one-cycle completion pulse
//   dbg_DO                  registered read data, held until the next ack
//   ram_E/RW/Size/A/DI      to ram256x8
//   ram_DO                  from ram256x8 (combinational read)
module ram_port_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic        clk,
    input  logic        R,
    input  logic        mem_E,
    input  logic        mem_RW,
    input  logic        mem_Size,
    input  logic [7:0]  mem_A,
    input  logic [31:0] mem_DI,
    output logic [31:0] mem_DO,
    output logic        mem_stall,
    input  logic        dbg_req,
    input  logic        dbg_RW,
    input  logic        dbg_Size,
    input  logic [7:0]  dbg_A,
    input  logic [31:0] dbg_DI,
    output logic        dbg_ack,
    output logic [31:0] dbg_DO,
    output logic        ram_E,
    output logic        ram_RW,
    output logic        ram_Size,
    output logic [7:0]  ram_A,
    output logic [31:0] ram_DI,
    input  logic [31:0] ram_DO
);

    typedef enum logic [1:0] {IDLE, STALL, ACK} state_t;

    typedef struct packed {
        logic        rw;
        logic        size;
        logic [7:0]  a;
        logic [31:0] di;
    } ram_req_t;

    // Last wait count before a stall is forced. With forcing disabled the
    // counter simply stays at zero.
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (MAX_WAIT == 0) ? '0 : WAIT_W'(MAX_WAIT - 1);

    state_t            state;
    logic [WAIT_W-1:0] wcnt;
    logic              use_dbg;
    logic              wait_hit;
    ram_req_t          mem_req;
    ram_req_t          dbg_rq;
    ram_req_t          sel_req;

    // Debug owns the RAM during a forced stall, or in an idle MEM cycle.
    assign use_dbg  = (state == STALL) || (state == IDLE && dbg_req && !mem_E);
    assign wait_hit = (MAX_WAIT != 0) && (wcnt == WAIT_LAST);

    assign mem_req = '{rw: mem_RW, size: mem_Size, a: mem_A, di: mem_DI};
    assign dbg_rq  = '{rw: dbg_RW, size: dbg_Size, a: dbg_A, di: dbg_DI};
    assign sel_req = use_dbg ? dbg_rq : mem_req;

    // Reset gates the enable so nothing commits while R is high.
    assign ram_E     = !R && (use_dbg || mem_E);
    assign ram_RW    = sel_req.rw;
    assign ram_Size  = sel_req.size;
    assign ram_A     = sel_req.a;
    assign ram_DI    = sel_req.di;
    assign mem_DO    = ram_DO;
    assign mem_stall = !R && (state == STALL);

    always_ff @(posedge clk) begin
        if (R) begin
            state   <= IDLE;
            wcnt    <= '0;
            dbg_ack <= 1'b0;
            dbg_DO  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dbg_req && !mem_E) begin
                        dbg_DO  <= ram_DO;
                        dbg_ack <= 1'b1;
                        wcnt    <= '0;
                        state   <= ACK;
                    end else if (dbg_req) begin
                        // Blocked by the MEM stage: count, or force a stall.
                        if (wait_hit)
                            state <= STALL;
                        else if (wcnt != WAIT_LAST)
                            wcnt <= wcnt + WAIT_W'(1);
                    end else begin
                        wcnt <= '0;
                    end
                end
                STALL: begin
                    dbg_DO  <= ram_DO;
                    dbg_ack <= 1'b1;
                    wcnt    <= '0;
                    state   <= ACK;
                end
                ACK: begin
                    // dbg_req is ignored here; requester drops or re-presents.
                    dbg_ack <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    dbg_ack <= 1'b0;
                    wcnt    <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: two instances (MAX_WAIT = 4 and MAX_WAIT = 0)
// share one stimulus stream, each with its own RAM. A per-instance
// behavioural model tracks request age and predicts every output each cycle.
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        R, mem_E, mem_RW, mem_Size, dbg_req, dbg_RW, dbg_Size;
    logic [7:0]  mem_A, dbg_A;
    logic [31:0] mem_DI, dbg_DI;

    logic [1:0]  mem_stall, dbg_ack, ram_E, ram_RW, ram_Size;
    logic [7:0]  ram_A  [2];
    logic [31:0] ram_DI [2];
    logic [31:0] ram_DO [2];
    logic [31:0] mem_DO [2];
    logic [31:0] dbg_DO [2];

    logic [7:0]  ram     [2][256];
    logic [7:0]  ref_mem [2][256];
    bit          ram_init = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        ram_port_arbiter #(.MAX_WAIT(k == 0 ? 4 : 0), .WAIT_W(3)) dut (
            .clk(clk), .R(R),
            .mem_E(mem_E), .mem_RW(mem_RW), .mem_Size(mem_Size),
            .mem_A(mem_A), .mem_DI(mem_DI), .mem_DO(mem_DO[k]),
            .mem_stall(mem_stall[k]),
            .dbg_req(dbg_req), .dbg_RW(dbg_RW), .dbg_Size(dbg_Size),
            .dbg_A(dbg_A), .dbg_DI(dbg_DI),
            .dbg_ack(dbg_ack[k]), .dbg_DO(dbg_DO[k]),
            .ram_E(ram_E[k]), .ram_RW(ram_RW[k]), .ram_Size(ram_Size[k]),
            .ram_A(ram_A[k]), .ram_DI(ram_DI[k]), .ram_DO(ram_DO[k])
        );
    end

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // ram256x8 stand-in: big-endian words, combinational read.
    always_comb begin
        logic [7:0] a;
        a = '0;
        for (int k = 0; k < 2; k++) begin
            a = ram_A[k];
            ram_DO[k] = ram_Size[k] ?
                {ram[k][a], ram[k][a + 8'd1], ram[k][a + 8'd2], ram[k][a + 8'd3]} :
                {24'h0, ram[k][a]};
        end
    end

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 256; i++) ram[k][i] <= pat(i);
            ram_init <= 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (ram_E[k] && ram_RW[k]) begin
                    if (ram_Size[k]) begin
                        ram[k][ram_A[k]]         <= ram_DI[k][31:24];
                        ram[k][ram_A[k] + 8'd1]  <= ram_DI[k][23:16];
                        ram[k][ram_A[k] + 8'd2]  <= ram_DI[k][15:8];
                        ram[k][ram_A[k] + 8'd3]  <= ram_DI[k][7:0];
                    end else begin
                        ram[k][ram_A[k]] <= ram_DI[k][7:0];
                    end
                end
            end
        end
    end

    function automatic logic [31:0] rd_ram(input int k, input logic [7:0] a, input logic sz);
        return sz ? {ram[k][a], ram[k][a + 8'd1], ram[k][a + 8'd2], ram[k][a + 8'd3]}
                  : {24'h0, ram[k][a]};
    endfunction

    function automatic logic [31:0] rd_ref(input int k, input logic [7:0] a, input logic sz);
        return sz ? {ref_mem[k][a], ref_mem[k][a + 8'd1], ref_mem[k][a + 8'd2], ref_mem[k][a + 8'd3]}
                  : {24'h0, ref_mem[k][a]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    // blocked: consecutive cycles this request has lost to the MEM stage.
    // stall_due: the request aged out and the next cycle steals the port.
    bit          started = 1'b0;
    int          blocked   [2];
    bit          in_ack    [2];
    bit          stall_due [2];
    logic [31:0] exp_do    [2];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int          mw;
            bit          sel, ee;
            logic [7:0]  ea;
            logic        esz, erw;
            logic [31:0] edi, rd;
            string       sfx;
            mw  = (k == 0) ? 4 : 0;
            sfx = $sformatf("[%0d]", k);
            if (!started)
                for (int i = 0; i < 256; i++) ref_mem[k][i] = pat(i);
            sel = stall_due[k] || (!in_ack[k] && dbg_req && !mem_E);
            ea  = sel ? dbg_A    : mem_A;
            esz = sel ? dbg_Size : mem_Size;
            erw = sel ? dbg_RW   : mem_RW;
            edi = sel ? dbg_DI   : mem_DI;
            ee  = !R && (sel || mem_E);
            rd  = rd_ref(k, ea, esz);
            if (started) begin
                chk({"ram_E", sfx}, 32'(ram_E[k]), 32'(ee));
                if (ee) begin
                    chk({"ram_RW", sfx},   32'(ram_RW[k]),   32'(erw));
                    chk({"ram_Size", sfx}, 32'(ram_Size[k]), 32'(esz));
                    chk({"ram_A", sfx},    32'(ram_A[k]),    32'(ea));
                    if (erw) chk({"ram_DI", sfx}, ram_DI[k], edi);
                end
                chk({"mem_stall", sfx}, 32'(mem_stall[k]), 32'(!R && stall_due[k]));
                chk({"dbg_ack", sfx},   32'(dbg_ack[k]),   32'(in_ack[k]));
                chk({"dbg_DO", sfx},    dbg_DO[k], exp_do[k]);
                chk({"mem_DO", sfx},    mem_DO[k], rd);
            end
            // state after the coming edge
            if (R) begin
                blocked[k] = 0; in_ack[k] = 0; stall_due[k] = 0; exp_do[k] = '0;
            end else if (sel) begin
                exp_do[k] = rd;
                if (erw) begin
                    if (esz) begin
                        ref_mem[k][ea] = edi[31:24]; ref_mem[k][ea + 8'd1] = edi[23:16];
                        ref_mem[k][ea + 8'd2] = edi[15:8]; ref_mem[k][ea + 8'd3] = edi[7:0];
                    end else ref_mem[k][ea] = edi[7:0];
                end
                in_ack[k] = 1; stall_due[k] = 0; blocked[k] = 0;
            end else begin
                if (mem_E && mem_RW) begin
                    if (mem_Size) begin
                        ref_mem[k][mem_A] = mem_DI[31:24]; ref_mem[k][mem_A + 8'd1] = mem_DI[23:16];
                        ref_mem[k][mem_A + 8'd2] = mem_DI[15:8]; ref_mem[k][mem_A + 8'd3] = mem_DI[7:0];
                    end else ref_mem[k][mem_A] = mem_DI[7:0];
                end
                if (in_ack[k]) in_ack[k] = 0;
                else if (dbg_req) begin
                    blocked[k]++;
                    if (mw != 0 && blocked[k] >= mw) stall_due[k] = 1;
                end else blocked[k] = 0;
            end
        end
        started = 1'b1;
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        R = 0; mem_E = 0; dbg_req = 0;
        repeat (n) next_cycle();
    endtask

    task automatic mem_write(input logic [7:0] a, input logic [31:0] d);
        R = 0; dbg_req = 0; mem_E = 1; mem_RW = 1; mem_Size = 1; mem_A = a; mem_DI = d;
        next_cycle();
        mem_E = 0; mem_RW = 0;
    endtask

    initial begin
        int bias;
        R = 1; mem_E = 1; mem_RW = 0; mem_Size = 1; mem_A = 8'h00; mem_DI = '0;
        dbg_req = 1; dbg_RW = 0; dbg_Size = 1; dbg_A = 8'h00; dbg_DI = '0;

        // 1. reset
        repeat (2) next_cycle();
        @(negedge clk);
        chk("t1_ram_E", 32'(ram_E[0]), 32'd0);
        chk("t1_ack", 32'(dbg_ack[0]), 32'd0);
        chk("t1_stall", 32'(mem_stall[0]), 32'd0);
        chk("t1_dbg_DO", dbg_DO[0], 32'd0);
        next_cycle();
        idle(2);

        // 2. idle debug read
        mem_write(8'd8, 32'hDEADBEEF);
        for (int c = 0; c < 3; c++) begin
            mem_E = 0; dbg_req = (c < 2); dbg_RW = 0; dbg_Size = 1; dbg_A = 8'd8;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("t2_ack%0d_c%0d", k, c), 32'(dbg_ack[k]), (c == 1) ? 32'd1 : 32'd0);
                chk($sformatf("t2_stall%0d_c%0d", k, c), 32'(mem_stall[k]), 32'd0);
                if (c == 1) chk($sformatf("t2_DO%0d", k), dbg_DO[k], 32'hDEADBEEF);
            end
            next_cycle();
        end

        // 3. debug write then MEM read
        dbg_req = 1; dbg_RW = 1; dbg_Size = 1; dbg_A = 8'd12; dbg_DI = 32'h12345678; mem_E = 0;
        repeat (2) next_cycle();
        dbg_req = 0; dbg_RW = 0; mem_E = 1; mem_RW = 0; mem_Size = 1; mem_A = 8'd12;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk($sformatf("t3_mem_DO%0d", k), mem_DO[k], 32'h12345678);
        next_cycle();
        idle(2);

        // 4. starvation, MAX_WAIT = 4
        for (int c = 0; c < 7; c++) begin
            mem_E = 1; mem_RW = 0; mem_Size = 1; mem_A = 8'd100;
            dbg_req = (c <= 5); dbg_RW = 0; dbg_A = 8'd20;
            @(negedge clk);
            chk($sformatf("t4_stall_c%0d", c), 32'(mem_stall[0]), (c == 4) ? 32'd1 : 32'd0);
            chk($sformatf("t4_ack_c%0d", c), 32'(dbg_ack[0]), (c == 5) ? 32'd1 : 32'd0);
            if (c <= 5) chk($sformatf("t4_ram_A_c%0d", c), 32'(ram_A[0]), (c == 4) ? 32'd20 : 32'd100);
            chk($sformatf("t4_stall1_c%0d", c), 32'(mem_stall[1]), 32'd0);
            next_cycle();
        end
        idle(2);

        // 5. MAX_WAIT = 0 never forces a stall
        for (int c = 0; c < 22; c++) begin
            mem_E = (c < 20); mem_RW = 0; dbg_req = 1; dbg_RW = 0; dbg_A = 8'd8;
            @(negedge clk);
            chk($sformatf("t5_ack_c%0d", c), 32'(dbg_ack[1]), (c == 21) ? 32'd1 : 32'd0);
            chk($sformatf("t5_stall_c%0d", c), 32'(mem_stall[1]), 32'd0);
            next_cycle();
        end
        idle(2);

        // 6. reset during STALL aborts the debug write
        mem_write(8'd40, 32'hCAFEF00D);
        idle(1);
        for (int c = 0; c < 7; c++) begin
            R = (c == 4); mem_E = 1; mem_RW = 0; mem_A = 8'd100;
            dbg_req = (c < 6); dbg_RW = 1; dbg_Size = 1; dbg_A = 8'd40; dbg_DI = 32'h11111111;
            @(negedge clk);
            if (c == 4) begin
                chk("t6_ram_E", 32'(ram_E[0]), 32'd0);
                chk("t6_stall", 32'(mem_stall[0]), 32'd0);
            end
            if (c == 5) chk("t6_ack", 32'(dbg_ack[0]), 32'd0);
            next_cycle();
        end
        chk("t6_ram_kept", rd_ram(0, 8'd40, 1'b1), 32'hCAFEF00D);
        idle(2);

        // random traffic with varying MEM load
        bias = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) bias = (c / 500) % 3 == 0 ? 30 : ((c / 500) % 3 == 1 ? 75 : 97);
            R        = ($urandom_range(0, 149) == 0);
            mem_E    = ($urandom_range(0, 99) < bias);
            mem_RW   = ($urandom_range(0, 3) == 0);
            mem_Size = 1'($urandom_range(0, 1));
            mem_A    = 8'($urandom);
            mem_DI   = $urandom;
            if (!dbg_req) begin
                dbg_RW   = ($urandom_range(0, 2) == 0);
                dbg_Size = 1'($urandom_range(0, 1));
                dbg_A    = 8'($urandom);
                dbg_DI   = $urandom;
            end
            if (dbg_ack[0] || $urandom_range(0, 5) == 0) dbg_req = 1'($urandom_range(0, 1));
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
